// File: rtl/regression_checker_pkg.sv
// Shared types for the regression pass/fail monitor: channel modes, FSM states, verdict causes.
package regression_checker_pkg;

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_FINAL = 2'd1,
    M_FIRST = 2'd2,
    M_NEVER = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_NONE     = 2'd0,
    C_SENTINEL = 2'd1,
    C_TIMEOUT  = 2'd2,
    C_EARLY    = 2'd3
  } cause_t;

endpackage

// File: rtl/regression_checker_chk.sv
// One watched-address channel: holds its config and run record; early_fail is same-cycle,
// final_fail reflects the end-of-run verdict from the registered record. No backpressure.
module chk_channel
  import regression_checker_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              ph2,
  input  logic              resetb,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [1:0]        cfg_mode,
  input  logic              clear,
  input  logic              run,
  input  logic              check,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              early_fail,
  output logic              final_fail,
  output logic              fail
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] exp_val;
  mode_t             mode;
  logic              seen;
  logic [DATA_W-1:0] last;
  logic              hit;

  assign hit = run && bus_we && (bus_addr == addr) && (mode != M_OFF);

  // FIRST only judges the very first write; later writes to the address are ignored.
  assign early_fail = hit && ((mode == M_NEVER) ||
                              ((mode == M_FIRST) && !seen && (bus_wdata != exp_val)));

  assign final_fail = ((mode == M_FINAL) && (!seen || (last != exp_val))) ||
                      ((mode == M_FIRST) && !seen);

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      addr    <= '0;
      exp_val <= '0;
      mode    <= M_OFF;
      seen    <= 1'b0;
      last    <= '0;
      fail    <= 1'b0;
    end else begin
      if (cfg_we) begin
        addr    <= cfg_addr;
        exp_val <= cfg_exp;
        mode    <= mode_t'(cfg_mode);
      end
      if (clear) begin
        seen <= 1'b0;
        last <= '0;
        fail <= 1'b0;
      end else begin
        if (hit) begin
          case (mode)
            M_FINAL: begin
              last <= bus_wdata;
              seen <= 1'b1;
            end
            M_FIRST: begin
              if (!seen) begin
                last <= bus_wdata;
                seen <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (early_fail || (check && final_fail)) fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regression_checker.sv
// Regression run monitor: snoops bus writes into NCHK channels, ends on sentinel/timeout/early fail.
// Verdict registered: early fail 1 cycle, sentinel/timeout 2 cycles (via CHECK). Never stalls the bus.
module regression_checker
  import regression_checker_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 8,
  parameter  int NCHK   = 4,
  parameter  int TMO_W  = 16,
  localparam int CIDX_W = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic              ph2,
  input  logic              resetb,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              cfg_we,
  input  logic [CIDX_W-1:0] cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] sentinel_addr,
  input  logic [TMO_W-1:0]  timeout,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [NCHK-1:0]   fail_mask,
  output logic [1:0]        cause,
  output logic [TMO_W-1:0]  cycles
);

  state_t           state;
  cause_t           cause_r;
  logic [TMO_W-1:0] cnt;
  logic [NCHK-1:0]  early_vec;
  logic [NCHK-1:0]  final_vec;
  logic [NCHK-1:0]  fail_vec;
  logic             clear;
  logic             in_idle;
  logic             sent_hit;

  assign in_idle  = (state == S_IDLE);
  assign clear    = start && ((state == S_IDLE) || (state == S_DONE));
  assign sent_hit = bus_we && (bus_addr == sentinel_addr);
  assign cause    = cause_r;

  for (genvar i = 0; i < NCHK; i++) begin : g_chan
    chk_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_chan (
      .ph2        (ph2),
      .resetb     (resetb),
      .cfg_we     (cfg_we && in_idle && (cfg_idx == CIDX_W'(i))),
      .cfg_addr   (cfg_addr),
      .cfg_exp    (cfg_exp),
      .cfg_mode   (cfg_mode),
      .clear      (clear),
      .run        (state == S_RUN),
      .check      (state == S_CHECK),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .early_fail (early_vec[i]),
      .final_fail (final_vec[i]),
      .fail       (fail_vec[i])
    );
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state     <= S_IDLE;
      cause_r   <= C_NONE;
      cnt       <= '0;
      cycles    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            cnt       <= timeout;
            cycles    <= '0;
            cause_r   <= C_NONE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
          end
        end
        S_RUN: begin
          cycles <= cycles + TMO_W'(1);
          if (cnt != '0) cnt <= cnt - TMO_W'(1);
          // Early fail outranks sentinel, which outranks timeout.
          if (|early_vec) begin
            state     <= S_DONE;
            cause_r   <= C_EARLY;
            fail_mask <= early_vec;
            pass      <= 1'b0;
            done      <= 1'b1;
          end else if (sent_hit) begin
            state   <= S_CHECK;
            cause_r <= C_SENTINEL;
          end else if (cnt == '0) begin
            state   <= S_CHECK;
            cause_r <= C_TIMEOUT;
          end
        end
        S_CHECK: begin
          state     <= S_DONE;
          fail_mask <= final_vec | fail_vec;
          pass      <= ~|(final_vec | fail_vec);
          done      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regression_checker.sv
// Vector-table bench for regression_checker with a done-event scoreboard.
module tb_regression_checker;

  localparam logic [1:0] OFF = 2'd0, FIN = 2'd1, FST = 2'd2, NEV = 2'd3;
  localparam logic [1:0] C_SENT = 2'd1, C_TMO = 2'd2, C_ERLY = 2'd3;
  localparam logic [15:0] SENT = 16'h00FF;
  localparam int NV = 10;

  logic        ph2 = 1'b0;
  logic        resetb = 1'b0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [7:0]  bus_wdata = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_addr = '0;
  logic [7:0]  cfg_exp = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] sentinel_addr = SENT;
  logic [15:0] timeout = '0;
  logic        start = 1'b0;
  logic        done;
  logic        pass;
  logic [3:0]  fail_mask;
  logic [1:0]  cause;
  logic [15:0] cycles;

  regression_checker #(.ADDR_W(16), .DATA_W(8), .NCHK(4), .TMO_W(16)) dut (
    .ph2(ph2), .resetb(resetb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_exp(cfg_exp),
    .cfg_mode(cfg_mode), .sentinel_addr(sentinel_addr), .timeout(timeout), .start(start),
    .done(done), .pass(pass), .fail_mask(fail_mask), .cause(cause), .cycles(cycles)
  );

  initial forever #5 ph2 = ~ph2;

  typedef struct packed {
    logic             rst;
    logic             cfg;
    logic             mid;
    logic             poke;
    logic [3:0][15:0] caddr;
    logic [3:0][7:0]  cexp;
    logic [3:0][1:0]  cmode;
    logic [15:0]      tmo;
    logic [2:0]       nw;
    logic [3:0][15:0] waddr;
    logic [3:0][7:0]  wdat;
    logic [7:0]       dly;
    logic             pass;
    logic [3:0]       fm;
    logic [1:0]       cause;
    logic [15:0]      cyc;
  } vec_t;

  typedef struct packed {
    logic [31:0] edge_no;
    logic        pass;
    logic [3:0]  fm;
    logic [1:0]  cause;
    logic [15:0] cyc;
  } exp_t;

  vec_t vecs[NV];
  vec_t v;
  exp_t sb[$];
  int   edge_n = 0;
  int   n_done = 0;
  int   total = 0;
  int   bad = 0;
  logic done_q = 1'b0;

  always @(posedge ph2) edge_n = edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: each rising done pops the verdict queued when the run was started.
  always @(negedge ph2) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_edge", edge_n, e.edge_no);
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("fail_mask", {28'd0, fail_mask}, {28'd0, e.fm});
        chk("cause", {30'd0, cause}, {30'd0, e.cause});
        chk("cycles", {16'd0, cycles}, {16'd0, e.cyc});
      end
      n_done = n_done + 1;
    end
    done_q = done;
  end

  task automatic new_vec(input logic rst, input logic cfg, input logic [15:0] tmo,
                         input logic [7:0] dly, input logic p, input logic [3:0] fm,
                         input logic [1:0] c, input logic [15:0] cyc);
    v = '0;
    v.rst = rst; v.cfg = cfg; v.tmo = tmo; v.dly = dly;
    v.pass = p; v.fm = fm; v.cause = c; v.cyc = cyc;
  endtask

  task automatic ch(input int c, input logic [15:0] a, input logic [7:0] e, input logic [1:0] m);
    v.caddr[c] = a; v.cexp[c] = e; v.cmode[c] = m;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    v.waddr[v.nw] = a; v.wdat[v.nw] = d; v.nw = v.nw + 3'd1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_fmask"}, {28'd0, fail_mask}, 32'd0);
    chk({tag, "_cause"}, {30'd0, cause}, 32'd0);
    chk({tag, "_cycles"}, {16'd0, cycles}, 32'd0);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    @(negedge ph2);
    @(negedge ph2);
    check_zero("rst");
    resetb = 1'b1;
    @(negedge ph2);
  endtask

  task automatic cfg_one(input int c, input logic [15:0] a, input logic [7:0] e, input logic [1:0] m);
    cfg_we = 1'b1; cfg_idx = 2'(c); cfg_addr = a; cfg_exp = e; cfg_mode = m;
    @(negedge ph2);
    cfg_we = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   s;
    int   tgt;

    new_vec(1, 1, 100, 4, 1, 4'b0000, C_SENT, 3);
    ch(0, 16'h0030, 8'h9D, FIN); wr(16'h0030, 8'h12); wr(16'h0030, 8'h9D); wr(SENT, 8'h00);
    vecs[0] = v;
    new_vec(0, 0, 100, 4, 0, 4'b0001, C_SENT, 3);
    wr(16'h0030, 8'h12); wr(16'h0030, 8'h9C); wr(SENT, 8'h00);
    vecs[1] = v;
    new_vec(1, 1, 100, 1, 0, 4'b0010, C_ERLY, 1);
    ch(1, 16'h0040, 8'h55, FST); wr(16'h0040, 8'h54); wr(16'h0040, 8'h55);
    vecs[2] = v;
    new_vec(1, 1, 20, 22, 1, 4'b0000, C_TMO, 21);
    ch(2, 16'h0200, 8'h00, NEV); v.poke = 1'b1;
    vecs[3] = v;
    new_vec(1, 1, 0, 2, 1, 4'b0000, C_SENT, 1);
    ch(3, SENT, 8'h01, FIN); wr(SENT, 8'h01);
    vecs[4] = v;
    new_vec(0, 0, 0, 2, 1, 4'b0000, C_TMO, 1);
    v.mid = 1'b1;
    vecs[5] = v;
    new_vec(1, 1, 100, 3, 0, 4'b0010, C_SENT, 2);
    ch(0, 16'h0030, 8'hAA, FIN); ch(1, 16'h0030, 8'hBB, FIN); wr(16'h0030, 8'hAA); wr(SENT, 8'h00);
    vecs[6] = v;
    new_vec(1, 1, 100, 1, 0, 4'b0100, C_ERLY, 1);
    ch(2, SENT, 8'h00, NEV); wr(SENT, 8'h00);
    vecs[7] = v;
    new_vec(1, 1, 3, 5, 0, 4'b0011, C_TMO, 4);
    ch(0, 16'h0030, 8'h11, FIN); ch(1, 16'h0040, 8'h22, FST);
    vecs[8] = v;
    new_vec(1, 1, 100, 4, 1, 4'b0000, C_SENT, 3);
    ch(1, 16'h0040, 8'h55, FST); wr(16'h0040, 8'h55); wr(16'h0040, 8'h00); wr(SENT, 8'h00);
    vecs[9] = v;

    @(negedge ph2);
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      if (v.mid) begin
        // Kill a run in flight; its config must not survive into the next run.
        do_reset();
        cfg_one(0, 16'h0030, 8'h9D, FIN);
        start = 1'b1; timeout = 16'd50;
        @(negedge ph2);
        start = 1'b0;
        repeat (3) @(negedge ph2);
        resetb = 1'b0;
        #2;
        check_zero("midrst");
        @(negedge ph2);
        resetb = 1'b1;
        @(negedge ph2);
      end
      if (v.cfg) for (int c = 0; c < 4; c++) cfg_one(c, v.caddr[c], v.cexp[c], v.cmode[c]);

      tgt = n_done + 1;
      start = 1'b1; timeout = v.tmo;
      @(posedge ph2);
      #1;
      s = edge_n;
      e.edge_no = 32'(s) + {24'd0, v.dly};
      e.pass = v.pass; e.fm = v.fm; e.cause = v.cause; e.cyc = v.cyc;
      sb.push_back(e);
      @(negedge ph2);
      start = 1'b0;
      for (int j = 0; j < int'(v.nw); j++) begin
        bus_we = 1'b1; bus_addr = v.waddr[j]; bus_wdata = v.wdat[j];
        @(negedge ph2);
      end
      bus_we = 1'b0;
      if (v.poke) begin
        // Both of these land mid-run and must be ignored.
        start = 1'b1;
        cfg_one(0, 16'h0030, 8'h9D, FIN);
        start = 1'b0;
      end
      for (int t = 0; t < 200 && n_done < tgt; t++) @(negedge ph2);
      if (n_done < tgt) begin
        chk("done_wait", 32'd0, 32'd1);
        if (sb.size() != 0) e = sb.pop_front();
      end
      @(negedge ph2);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
